// File: rtl/core_reset_seq.sv
// Core reset sequencer: holds hard and core reset across config changes, downloads and
// user requests, and releases the core only once every required ROM index has been loaded.
module core_reset_seq #(
  parameter int unsigned          WATCH_W   = 8,
  parameter int unsigned          HOLD_W    = 16,
  parameter int unsigned          HARD_HOLD = 16'hFFFF,
  parameter int unsigned          SOFT_HOLD = 16,
  parameter int unsigned          NUM_ROMS  = 1,
  parameter logic [NUM_ROMS-1:0]  REQ_MASK  = '1
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  input  logic [WATCH_W-1:0]  cfg_watch,
  input  logic                hard_req,
  input  logic                soft_req,
  input  logic                ioctl_download,
  input  logic [7:0]          ioctl_index,
  output logic                hard_reset,
  output logic                core_reset,
  output logic [NUM_ROMS-1:0] rom_loaded,
  output logic                all_loaded,
  output logic [2:0]          state
);

  typedef enum logic [2:0] {
    HARD     = 3'd0,
    WAIT_ROM = 3'd1,
    SOFT     = 3'd2,
    RUN      = 3'd3
  } state_t;

  localparam logic [HOLD_W-1:0] HARD_LD = HOLD_W'(HARD_HOLD);
  localparam logic [HOLD_W-1:0] SOFT_LD = HOLD_W'(SOFT_HOLD);

  state_t              state_q, state_d;
  logic [HOLD_W-1:0]   cnt_q, cnt_d;
  logic [WATCH_W-1:0]  cfg_d;
  logic                armed;
  logic                dl_d;
  logic [7:0]          idx_q;
  logic [NUM_ROMS-1:0] rom_set;
  logic                cfg_chg;
  logic                hard_cause;

  // armed lags reset release by one edge so the first cfg sample is never a change
  assign cfg_chg    = armed & (|(cfg_watch ^ cfg_d));
  assign hard_cause = hard_req | ioctl_download | cfg_chg;
  assign all_loaded = &(rom_loaded | ~REQ_MASK);
  assign state      = state_q;

  always_comb begin
    rom_set = '0;
    if (dl_d && !ioctl_download) begin
      for (int unsigned i = 0; i < NUM_ROMS; i++) begin
        if (idx_q == 8'(i)) rom_set[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (hard_cause) begin
      state_d = HARD;
      cnt_d   = HARD_LD;
    end else begin
      unique case (state_q)
        HARD: begin
          if (cnt_q == '0) begin
            if (all_loaded) begin
              state_d = SOFT;
              cnt_d   = SOFT_LD;
            end else begin
              state_d = WAIT_ROM;
            end
          end else begin
            cnt_d = cnt_q - HOLD_W'(1);
          end
        end
        WAIT_ROM: begin
          if (all_loaded) begin
            state_d = SOFT;
            cnt_d   = SOFT_LD;
          end
        end
        SOFT: begin
          if (soft_req) begin
            cnt_d = SOFT_LD;
          end else if (cnt_q == '0) begin
            state_d = RUN;
          end else begin
            cnt_d = cnt_q - HOLD_W'(1);
          end
        end
        RUN: begin
          if (soft_req) begin
            state_d = SOFT;
            cnt_d   = SOFT_LD;
          end
        end
        default: begin
          state_d = HARD;
          cnt_d   = HARD_LD;
        end
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= HARD;
      cnt_q      <= HARD_LD;
      hard_reset <= 1'b1;
      core_reset <= 1'b1;
      rom_loaded <= '0;
      cfg_d      <= '0;
      armed      <= 1'b0;
      dl_d       <= 1'b0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hard_reset <= (state_d == HARD);
      core_reset <= (state_d != RUN);
      rom_loaded <= rom_loaded | rom_set;
      cfg_d      <= cfg_watch;
      armed      <= 1'b1;
      dl_d       <= ioctl_download;
      if (ioctl_download) idx_q <= ioctl_index;
    end
  end

endmodule

// File: tb/tb_core_reset_seq.sv
// Directed bench for core_reset_seq: reset release, downloads, config change,
// soft/hard request interplay and asynchronous reset abort.
module tb_core_reset_seq;

  logic       clk_sys = 1'b0;
  logic       reset_n;
  logic [3:0] cfg_watch;
  logic       hard_req;
  logic       soft_req;
  logic       ioctl_download;
  logic [7:0] ioctl_index;
  logic       hard_reset;
  logic       core_reset;
  logic [1:0] rom_loaded;
  logic       all_loaded;
  logic [2:0] state;

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clk_sys = ~clk_sys;

  core_reset_seq #(
    .WATCH_W   (4),
    .HOLD_W    (16),
    .HARD_HOLD (8),
    .SOFT_HOLD (4),
    .NUM_ROMS  (2),
    .REQ_MASK  (2'b01)
  ) dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .cfg_watch      (cfg_watch),
    .hard_req       (hard_req),
    .soft_req       (soft_req),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .hard_reset     (hard_reset),
    .core_reset     (core_reset),
    .rom_loaded     (rom_loaded),
    .all_loaded     (all_loaded),
    .state          (state)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [2:0] st, input logic hr,
                          input logic cr, input logic [1:0] rl);
    chk({tag, ".state"}, 32'(state), 32'(st));
    chk({tag, ".hard"},  32'(hard_reset), 32'(hr));
    chk({tag, ".core"},  32'(core_reset), 32'(cr));
    chk({tag, ".roms"},  32'(rom_loaded), 32'(rl));
  endtask

  initial begin
    reset_n        = 1'b0;
    cfg_watch      = 4'h0;
    hard_req       = 1'b0;
    soft_req       = 1'b0;
    ioctl_download = 1'b0;
    ioctl_index    = 8'h00;
    tick(3);
    chk_outs("rst", 3'd0, 1'b1, 1'b1, 2'b00);
    chk("rst.all", 32'(all_loaded), 32'd0);

    // Release with no download: 9 edges of hard reset then WAIT_ROM forever
    reset_n = 1'b1;
    tick(8);
    chk_outs("rel8", 3'd0, 1'b1, 1'b1, 2'b00);
    tick(1);
    chk_outs("rel9", 3'd1, 1'b0, 1'b1, 2'b00);
    tick(30);
    chk_outs("wait", 3'd1, 1'b0, 1'b1, 2'b00);

    // Download index 1 only: forces HARD, marks bit 1, but core stays held
    ioctl_download = 1'b1;
    ioctl_index    = 8'd1;
    tick(1);
    chk_outs("dl1.start", 3'd0, 1'b1, 1'b1, 2'b00);
    tick(4);
    ioctl_download = 1'b0;
    ioctl_index    = 8'd0;
    tick(1);
    chk_outs("dl1.fall", 3'd0, 1'b1, 1'b1, 2'b10);
    chk("dl1.all", 32'(all_loaded), 32'd0);
    tick(7);
    chk_outs("dl1.h8", 3'd0, 1'b1, 1'b1, 2'b10);
    tick(1);
    chk_outs("dl1.h9", 3'd1, 1'b0, 1'b1, 2'b10);
    tick(20);
    chk_outs("dl1.wait", 3'd1, 1'b0, 1'b1, 2'b10);

    // Mid-sequence async reset discards loaded flags
    reset_n = 1'b0;
    #1;
    chk_outs("abort", 3'd0, 1'b1, 1'b1, 2'b00);
    tick(2);

    // Download index 0 for 20 cycles from reset release
    reset_n        = 1'b1;
    ioctl_download = 1'b1;
    ioctl_index    = 8'd0;
    tick(20);
    chk_outs("dl0.hold", 3'd0, 1'b1, 1'b1, 2'b00);
    ioctl_download = 1'b0;
    tick(1);
    chk_outs("dl0.fall", 3'd0, 1'b1, 1'b1, 2'b01);
    chk("dl0.all", 32'(all_loaded), 32'd1);
    tick(7);
    chk_outs("dl0.h8", 3'd0, 1'b1, 1'b1, 2'b01);
    tick(1);
    chk_outs("dl0.soft1", 3'd2, 1'b0, 1'b1, 2'b01);
    tick(4);
    chk_outs("dl0.soft5", 3'd2, 1'b0, 1'b1, 2'b01);
    tick(1);
    chk_outs("dl0.run", 3'd3, 1'b0, 1'b0, 2'b01);
    tick(10);
    chk_outs("dl0.run2", 3'd3, 1'b0, 1'b0, 2'b01);

    // Watched config change in RUN forces HARD on the next edge
    cfg_watch = 4'h2;
    tick(1);
    chk_outs("cfg.hard", 3'd0, 1'b1, 1'b1, 2'b01);
    tick(8);
    chk_outs("cfg.h9", 3'd0, 1'b1, 1'b1, 2'b01);
    tick(1);
    chk_outs("cfg.soft", 3'd2, 1'b0, 1'b1, 2'b01);
    tick(4);
    chk_outs("cfg.soft5", 3'd2, 1'b0, 1'b1, 2'b01);
    tick(1);
    chk_outs("cfg.run", 3'd3, 1'b0, 1'b0, 2'b01);

    // soft_req for 3 cycles, then hard_req on top of it wins
    soft_req = 1'b1;
    tick(3);
    chk_outs("soft.hold", 3'd2, 1'b0, 1'b1, 2'b01);
    hard_req = 1'b1;
    tick(1);
    chk_outs("soft.hard", 3'd0, 1'b1, 1'b1, 2'b01);
    hard_req = 1'b0;
    soft_req = 1'b0;
    tick(8);
    chk_outs("soft.h8", 3'd0, 1'b1, 1'b1, 2'b01);
    tick(1);
    chk_outs("soft.s1", 3'd2, 1'b0, 1'b1, 2'b01);
    tick(5);
    chk_outs("soft.run", 3'd3, 1'b0, 1'b0, 2'b01);

    // One-cycle reset pulse during SOFT
    soft_req = 1'b1;
    tick(1);
    soft_req = 1'b0;
    chk_outs("pulse.soft", 3'd2, 1'b0, 1'b1, 2'b01);
    reset_n = 1'b0;
    #1;
    chk_outs("pulse.async", 3'd0, 1'b1, 1'b1, 2'b00);
    chk("pulse.all", 32'(all_loaded), 32'd0);
    tick(1);
    // cfg_watch is still 4'h2 here: the first sample after release must not count
    reset_n = 1'b1;
    tick(8);
    chk_outs("pulse.h8", 3'd0, 1'b1, 1'b1, 2'b00);
    tick(1);
    chk_outs("pulse.h9", 3'd1, 1'b0, 1'b1, 2'b00);

    // Out-of-range download index sets no flag
    ioctl_download = 1'b1;
    ioctl_index    = 8'd5;
    tick(2);
    ioctl_download = 1'b0;
    tick(1);
    chk_outs("idx5.fall", 3'd0, 1'b1, 1'b1, 2'b00);
    tick(8);
    chk_outs("idx5.wait", 3'd1, 1'b0, 1'b1, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/core_reset_seq.md
CORE_RESET_SEQ -- requirements
Module: core_reset_seq

Interface
REQ-001 The block SHALL have parameter WATCH_W, default 8: width of the watched configuration vector.
REQ-002 The block SHALL have parameter HOLD_W, default 16: width of the hold counter.
REQ-003 The block SHALL have parameter HARD_HOLD, default 16'hFFFF: cycles hard_reset stays high after the last hard cause drops.
REQ-004 The block SHALL have parameter SOFT_HOLD, default 16: cycles core_reset stays high after soft_req drops.
REQ-005 The block SHALL have parameter NUM_ROMS, default 1 (range 1..8): number of tracked ioctl download indices, 0..NUM_ROMS-1.
REQ-006 The block SHALL have parameter REQ_MASK, NUM_ROMS bits, default all ones: indices that must be loaded before the core runs.
REQ-007 The block SHALL have port clk_sys, input, 1 bit: single system clock, rising edge.
REQ-008 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset (typically pll locked).
REQ-009 The block SHALL have port cfg_watch, input, WATCH_W bits: OSD options whose change forces a hard reset.
REQ-010 The block SHALL have port hard_req, input, 1 bit: level request for a hard reset (menu hard reset, cart remove).
REQ-011 The block SHALL have port soft_req, input, 1 bit: level request for a soft reset (menu reset, button).
REQ-012 The block SHALL have port ioctl_download, input, 1 bit: data_io download active.
REQ-013 The block SHALL have port ioctl_index, input, 8 bits: data_io download index.
REQ-014 The block SHALL have port hard_reset, output, 1 bit: registered hard reset.
REQ-015 The block SHALL have port core_reset, output, 1 bit: registered active-high core reset.
REQ-016 The block SHALL have port rom_loaded, output, NUM_ROMS bits: per-index loaded flags.
REQ-017 The block SHALL have port all_loaded, output, 1 bit: true when (rom_loaded | ~REQ_MASK) is all ones.
REQ-018 The block SHALL have port state, output, 3 bits: HARD=0, WAIT_ROM=1, SOFT=2, RUN=3.

Function
REQ-019 The block SHALL define hard_cause = hard_req | ioctl_download | cfg_chg.
REQ-020 The block SHALL compute cfg_chg = armed & |(cfg_watch ^ cfg_d); cfg_d registers cfg_watch every cycle; armed is set one cycle after reset_n release, so the first sample never counts as a change.
REQ-021 The block SHALL latch ioctl_index into idx_q on every cycle where ioctl_download=1.
REQ-022 On a falling edge of ioctl_download (registered dl_d=1, ioctl_download=0), the block SHALL set rom_loaded[idx_q] when idx_q < NUM_ROMS; other indices are ignored.
REQ-023 rom_loaded bits SHALL be sticky and cleared only by reset_n.
REQ-024 In HARD, the outputs SHALL be hard_reset=1 and core_reset=1; cnt reloads to HARD_HOLD while hard_cause, else decrements.
REQ-025 In HARD, when cnt==0 and !hard_cause, the block SHALL go to SOFT (cnt<=SOFT_HOLD) if all_loaded, else to WAIT_ROM.
REQ-026 In WAIT_ROM, the outputs SHALL be hard_reset=0 and core_reset=1; the block goes to SOFT (cnt<=SOFT_HOLD) when all_loaded.
REQ-027 In SOFT, the outputs SHALL be hard_reset=0 and core_reset=1; cnt reloads to SOFT_HOLD while soft_req, else decrements; at cnt==0 and !soft_req the block goes to RUN.
REQ-028 In RUN, both resets SHALL be 0; soft_req goes to SOFT (cnt<=SOFT_HOLD).
REQ-029 From any state, hard_cause SHALL go to HARD (cnt<=HARD_HOLD) and take priority over soft_req and all_loaded in the same cycle.
REQ-030 All outputs SHALL be registered; a cause sampled at edge n is visible after edge n+1.
REQ-031 cnt SHALL saturate at 0 and never wrap; HARD_HOLD=0 or SOFT_HOLD=0 is legal and means exit on the first cycle without a cause.
REQ-032 A download completing while in HARD SHALL set its rom_loaded bit in the same cycle, and that bit SHALL count for the HARD exit decision on the following cycle.

Reset
REQ-033 While reset_n=0 (asynchronous), the block SHALL hold state=HARD, cnt=HARD_HOLD, hard_reset=1, core_reset=1, rom_loaded=0, cfg_d=0, armed=0, dl_d=0, idx_q=0.
REQ-034 When reset_n is asserted mid-sequence, the block SHALL abort immediately to these values, discarding loaded flags.

Verification (HARD_HOLD=8, SOFT_HOLD=4, NUM_ROMS=2, REQ_MASK=2'b01, WATCH_W=4)
REQ-035 Release reset_n with no download: the bench SHALL see hard_reset fall after 9 cycles, state=WAIT_ROM, and core_reset held high indefinitely.
REQ-036 Download index 0 for 20 cycles: the bench SHALL see hard_reset high throughout plus 9 cycles, rom_loaded=2'b01, SOFT for 5 cycles, then RUN with core_reset=0.
REQ-037 Download index 1 only: the bench SHALL see rom_loaded=2'b10, all_loaded=0, and state remaining in WAIT_ROM.
REQ-038 In RUN, toggle cfg_watch 4'h0->4'h2: the bench SHALL see hard_reset=1 on the next edge, with the rom_loaded flags retained and RUN regained after 9+5 cycles.
REQ-039 In RUN, assert soft_req 3 cycles then hard_req together with soft_req: the bench SHALL see SOFT with hard_reset=0, then HARD on hard_req.
REQ-040 Pulse reset_n low for 1 cycle during SOFT: the bench SHALL see all outputs take their reset values asynchronously and rom_loaded=0.
